// File: rtl/sr_latch_pulse_sched.sv
// Round-robin controller for a bank of NAND SR latches with active-low S/R.
// A granted request produces one timed low pulse on a single S or R line,
// followed by an all-high recovery gap and a one-cycle feedback check with ack.
module sr_latch_pulse_sched #(
  parameter int NREQ    = 2,
  parameter int NLATCH  = 8,
  parameter int AW      = 3,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      ack,
  output logic [NLATCH-1:0]    s_n,
  output logic [NLATCH-1:0]    r_n,
  input  logic [NLATCH-1:0]    q_fb,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr,
  output logic [NLATCH-1:0]    shadow
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, RECOVER, CHECK} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_g;
  logic                r_op;
  logic [AW-1:0]       r_addr;

  logic [NREQ-1:0]     r_ack;
  logic [NLATCH-1:0]   r_s_n;
  logic [NLATCH-1:0]   r_r_n;
  logic                r_busy;
  logic                r_err;
  logic [NLATCH-1:0]   r_shadow;

  logic                w_any;
  logic                w_found;
  logic [PW-1:0]       w_gnt;
  logic                w_gnt_op;
  logic [AW-1:0]       w_gnt_addr;
  logic                w_op_cur;
  logic [AW-1:0]       w_addr_cur;
  logic                w_addr_ok;
  logic                w_chk_addr_ok;
  logic                w_q_sel;
  logic                w_chk_ok;
  logic [NLATCH-1:0]   w_s_n_nxt;
  logic [NLATCH-1:0]   w_r_n_nxt;
  logic [NREQ-1:0]     w_ack_nxt;

  assign ack    = r_ack;
  assign s_n    = r_s_n;
  assign r_n    = r_r_n;
  assign busy   = r_busy;
  assign err    = r_err;
  assign shadow = r_shadow;

  assign w_any = |req;

  // Round-robin pick: first request at/after the pointer, else first from bit 0
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_gnt   = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[i]) begin
        w_found = 1'b1;
        w_gnt   = PW'(i);
      end
    end
  end

  // Mux the granted requester's op and address
  always_comb begin
    w_gnt_op   = 1'b0;
    w_gnt_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == w_gnt) begin
        w_gnt_op   = op[i];
        w_gnt_addr = addr[i*AW +: AW];
      end
    end
  end

  // In IDLE the operation being launched is the fresh grant, otherwise the captured one
  assign w_op_cur      = (r_state == IDLE) ? w_gnt_op   : r_op;
  assign w_addr_cur    = (r_state == IDLE) ? w_gnt_addr : r_addr;
  assign w_addr_ok     = (int'(w_addr_cur) < NLATCH);
  assign w_chk_addr_ok = (int'(r_addr) < NLATCH);

  // Select the feedback bit of the latch under check
  always_comb begin
    w_q_sel = 1'b0;
    for (int i = 0; i < NLATCH; i++) begin
      if (int'(r_addr) == i) w_q_sel = q_fb[i];
    end
  end

  assign w_chk_ok = w_chk_addr_ok && (w_q_sel == r_op);

  // Next-state and phase counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = CW'(PULSE_W);
        end
      end
      PULSE: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = CW'(GAP_W);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = CHECK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output values for the next cycle; at most one line low, only while pulsing a valid address
  always_comb begin
    w_s_n_nxt = '1;
    w_r_n_nxt = '1;
    w_ack_nxt = '0;
    if (w_state_nxt == PULSE && w_addr_ok) begin
      for (int i = 0; i < NLATCH; i++) begin
        if (int'(w_addr_cur) == i) begin
          if (w_op_cur) w_s_n_nxt[i] = 1'b0;
          else          w_r_n_nxt[i] = 1'b0;
        end
      end
    end
    if (w_state_nxt == CHECK) w_ack_nxt = NREQ'(1) << r_g;
  end

  // Control state, registered outputs, sticky error and shadow image
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_s_n    <= '1;
      r_r_n    <= '1;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s_n   <= w_s_n_nxt;
      r_r_n   <= w_r_n_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (r_state == IDLE && w_any) begin
        r_ptr <= (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;
      end
      if (r_state == CHECK && !w_chk_ok) r_err <= 1'b1;
      else if (err_clr)                  r_err <= 1'b0;
      if (r_state == CHECK && w_chk_addr_ok) begin
        for (int i = 0; i < NLATCH; i++) begin
          if (int'(r_addr) == i) r_shadow[i] <= r_op;
        end
      end
    end
  end

  // Capture the granted operation; held until the next grant
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_any) begin
      r_op   <= w_gnt_op;
      r_addr <= w_gnt_addr;
      r_g    <= w_gnt;
    end
  end

endmodule
